// File: rtl/y86_pkg.sv
// Y86-64 shared encodings: instruction codes, register IDs, status codes
// and the D->E pipeline register layout with its bubble/reset value.
package y86_pkg;

    localparam int unsigned NREG = 15;
    localparam int unsigned XLEN = 64;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_t;

    typedef enum logic [3:0] {
        S_AOK = 4'h1,
        S_HLT = 4'h2,
        S_ADR = 4'h3,
        S_INS = 4'h4
    } stat_t;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef struct packed {
        logic [3:0]      stat;
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [XLEN-1:0] val_c;
        logic [XLEN-1:0] val_a;
        logic [XLEN-1:0] val_b;
        logic [3:0]      dst_e;
        logic [3:0]      dst_m;
        logic [3:0]      src_a;
        logic [3:0]      src_b;
    } e_reg_t;

    // Inserted bubble is a nop with no register effects; also the reset value.
    localparam e_reg_t E_BUBBLE = '{
        stat:  S_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        val_c: '0,
        val_a: '0,
        val_b: '0,
        dst_e: RNONE,
        dst_m: RNONE,
        src_a: RNONE,
        src_b: RNONE
    };

endpackage

// File: rtl/decode_fwd_mux.sv
// Operand selector for one decode source: picks the newest in-flight result
// for the source register, or the register-file value when nothing matches.
// Forwarding is compiled in only when DECODE_FWD_EN is defined; otherwise
// the pipeline inputs are ignored and the hazard unit must stall on RAW.
module decode_fwd_mux
    import y86_pkg::*;
(
    input  logic [3:0]      src,
    input  logic [XLEN-1:0] reg_val,
    input  logic [3:0]      e_dst_e,
    input  logic [XLEN-1:0] e_val_e,
    input  logic [3:0]      m_dst_m,
    input  logic [XLEN-1:0] m_val_m,
    input  logic [3:0]      m_dst_e,
    input  logic [XLEN-1:0] m_val_e,
    input  logic [3:0]      w_dst_m,
    input  logic [XLEN-1:0] w_val_m,
    input  logic [3:0]      w_dst_e,
    input  logic [XLEN-1:0] w_val_e,
    output logic [XLEN-1:0] val
);

`ifdef DECODE_FWD_EN
    // Priority select, youngest producer first; src==RNONE short-circuits so
    // an RNONE destination can never match.
    always_comb begin
        val = reg_val;
        if (src == RNONE)
            val = '0;
        else if (src == e_dst_e)
            val = e_val_e;
        else if (src == m_dst_m)
            val = m_val_m;
        else if (src == m_dst_e)
            val = m_val_e;
        else if (src == w_dst_m)
            val = w_val_m;
        else if (src == w_dst_e)
            val = w_val_e;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{e_dst_e, e_val_e, m_dst_m, m_val_m, m_dst_e, m_val_e,
                          w_dst_m, w_val_m, w_dst_e, w_val_e};

    // Register read only; RNONE reads as zero.
    always_comb begin
        val = reg_val;
        if (src == RNONE)
            val = '0;
    end
`endif

endmodule

// File: rtl/decode_reg_read.sv
// Y86-64 decode stage: derives source/destination register IDs, reads the
// register file, selects operands (with forwarding when DECODE_FWD_EN is
// defined) and registers the result into the D->E pipeline register.
module decode_reg_read
    import y86_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           D_stat,
    input  logic [3:0]           D_icode,
    input  logic [3:0]           D_ifun,
    input  logic [3:0]           D_rA,
    input  logic [3:0]           D_rB,
    input  logic [XLEN-1:0]      D_valC,
    input  logic [XLEN-1:0]      D_valP,
    input  logic [NREG*XLEN-1:0] reg_file_flat,
    input  logic [3:0]           e_dstE,
    input  logic [3:0]           M_dstE,
    input  logic [3:0]           M_dstM,
    input  logic [3:0]           W_dstE,
    input  logic [3:0]           W_dstM,
    input  logic [XLEN-1:0]      e_valE,
    input  logic [XLEN-1:0]      M_valE,
    input  logic [XLEN-1:0]      m_valM,
    input  logic [XLEN-1:0]      W_valE,
    input  logic [XLEN-1:0]      W_valM,
    input  logic                 E_stall,
    input  logic                 E_bubble,
    output logic [3:0]           d_srcA,
    output logic [3:0]           d_srcB,
    output logic [3:0]           E_stat,
    output logic [3:0]           E_icode,
    output logic [3:0]           E_ifun,
    output logic [XLEN-1:0]      E_valC,
    output logic [XLEN-1:0]      E_valA,
    output logic [XLEN-1:0]      E_valB,
    output logic [3:0]           E_dstE,
    output logic [3:0]           E_dstM,
    output logic [3:0]           E_srcA,
    output logic [3:0]           E_srcB
);

    logic [3:0]      d_dstE;
    logic [3:0]      d_dstM;
    logic [XLEN-1:0] reg_a;
    logic [XLEN-1:0] reg_b;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] d_valA;
    e_reg_t          e_d;
    e_reg_t          e_q;

    // Register ID decode from the instruction code.
    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (D_icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA = D_rA;
            I_RET, I_POPQ:                      d_srcA = RRSP;
            default:                            d_srcA = RNONE;
        endcase
        case (D_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          d_srcB = D_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_srcB = RRSP;
            default:                            d_srcB = RNONE;
        endcase
        case (D_icode)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:          d_dstE = D_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_dstE = RRSP;
            default:                            d_dstE = RNONE;
        endcase
        case (D_icode)
            I_MRMOVQ, I_POPQ:                   d_dstM = D_rA;
            default:                            d_dstM = RNONE;
        endcase
    end

    // Register file read; IDs outside 0..NREG-1 (i.e. RNONE) read as zero.
    always_comb begin
        reg_a = '0;
        reg_b = '0;
        for (int unsigned k = 0; k < NREG; k++) begin
            if (d_srcA == k[3:0])
                reg_a = reg_file_flat[k*XLEN +: XLEN];
            if (d_srcB == k[3:0])
                reg_b = reg_file_flat[k*XLEN +: XLEN];
        end
    end

    decode_fwd_mux u_fwd_a (
        .src     (d_srcA),
        .reg_val (reg_a),
        .e_dst_e (e_dstE),
        .e_val_e (e_valE),
        .m_dst_m (M_dstM),
        .m_val_m (m_valM),
        .m_dst_e (M_dstE),
        .m_val_e (M_valE),
        .w_dst_m (W_dstM),
        .w_val_m (W_valM),
        .w_dst_e (W_dstE),
        .w_val_e (W_valE),
        .val     (fwd_a)
    );

    decode_fwd_mux u_fwd_b (
        .src     (d_srcB),
        .reg_val (reg_b),
        .e_dst_e (e_dstE),
        .e_val_e (e_valE),
        .m_dst_m (M_dstM),
        .m_val_m (m_valM),
        .m_dst_e (M_dstE),
        .m_val_e (M_valE),
        .w_dst_m (W_dstM),
        .w_val_m (W_valM),
        .w_dst_e (W_dstE),
        .w_val_e (W_valE),
        .val     (fwd_b)
    );

    // jXX and call carry the fall-through PC in valA instead of a register.
    always_comb begin
        d_valA = fwd_a;
        if (D_icode == I_JXX || D_icode == I_CALL)
            d_valA = D_valP;
    end

    // Next value of the E register.
    always_comb begin
        e_d       = E_BUBBLE;
        e_d.stat  = D_stat;
        e_d.icode = D_icode;
        e_d.ifun  = D_ifun;
        e_d.val_c = D_valC;
        e_d.val_a = d_valA;
        e_d.val_b = fwd_b;
        e_d.dst_e = d_dstE;
        e_d.dst_m = d_dstM;
        e_d.src_a = d_srcA;
        e_d.src_b = d_srcB;
    end

    // D->E pipeline register: bubble beats stall, stall holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            e_q <= E_BUBBLE;
        else if (E_bubble)
            e_q <= E_BUBBLE;
        else if (!E_stall)
            e_q <= e_d;
    end

    assign E_stat  = e_q.stat;
    assign E_icode = e_q.icode;
    assign E_ifun  = e_q.ifun;
    assign E_valC  = e_q.val_c;
    assign E_valA  = e_q.val_a;
    assign E_valB  = e_q.val_b;
    assign E_dstE  = e_q.dst_e;
    assign E_dstM  = e_q.dst_m;
    assign E_srcA  = e_q.src_a;
    assign E_srcB  = e_q.src_b;

endmodule

// File: tb/tb_decode_reg_read.sv
// Directed bench for decode_reg_read: vector table for decode/read/forward,
// plus hand-written reset, stall and bubble sequences.
module tb_decode_reg_read;

    localparam logic [3:0] N = 4'hF;

`ifdef DECODE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   D_stat, D_icode, D_ifun, D_rA, D_rB;
    logic [63:0]  D_valC, D_valP;
    logic [959:0] reg_file_flat;
    logic [3:0]   e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0]  e_valE, M_valE, m_valM, W_valE, W_valM;
    logic         E_stall, E_bubble;
    logic [3:0]   d_srcA, d_srcB;
    logic [3:0]   E_stat, E_icode, E_ifun;
    logic [63:0]  E_valC, E_valA, E_valB;
    logic [3:0]   E_dstE, E_dstM, E_srcA, E_srcB;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    decode_reg_read dut (
        .clk(clk), .rst(rst),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .reg_file_flat(reg_file_flat),
        .e_dstE(e_dstE), .M_dstE(M_dstE), .M_dstM(M_dstM), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .e_valE(e_valE), .M_valE(M_valE), .m_valM(m_valM), .W_valE(W_valE), .W_valM(W_valM),
        .E_stall(E_stall), .E_bubble(E_bubble),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    typedef struct {
        logic [3:0]  stat, icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic [3:0]  fe, fme, fmm, fwe, fwm;     // e_dstE, M_dstE, M_dstM, W_dstE, W_dstM
        logic [3:0]  x_srca, x_srcb, x_dste, x_dstm;
        logic [63:0] x_vala_f, x_vala_n, x_valb_f, x_valb_n;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_vec(input vec_t v);
        D_stat  = v.stat;  D_icode = v.icode; D_ifun = v.ifun;
        D_rA    = v.ra;    D_rB    = v.rb;
        D_valC  = v.valc;  D_valP  = v.valp;
        e_dstE  = v.fe;    M_dstE  = v.fme;   M_dstM = v.fmm;
        W_dstE  = v.fwe;   W_dstM  = v.fwm;
    endtask

    initial begin
        // stat icode ifun rA rB valC valP | e M_E M_M W_E W_M | srcA srcB dstE dstM | valA(fwd,nofwd) valB(fwd,nofwd)
        vecs[0]  = '{4'h1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0,    64'h0,  N, N, N, N, N, 4'h2, 4'h3, 4'h3, N,    64'h2,  64'h2,  64'h3,  64'h3};
        vecs[1]  = '{4'h1, 4'h6, 4'h1, 4'h5, 4'h1, 64'h0,    64'h0,  4'h5, 4'h5, N, N, N, 4'h5, 4'h1, 4'h1, N, 64'hAA, 64'h5, 64'h1, 64'h1};
        vecs[2]  = '{4'h1, 4'h6, 4'h1, 4'h5, 4'h1, 64'h0,    64'h0,  N, 4'h5, N, N, N, 4'h5, 4'h1, 4'h1, N,    64'hBB, 64'h5, 64'h1, 64'h1};
        vecs[3]  = '{4'h1, 4'h6, 4'h1, 4'h5, 4'h1, 64'h0,    64'h0,  N, 4'h5, 4'h5, N, N, 4'h5, 4'h1, 4'h1, N, 64'hCC, 64'h5, 64'h1, 64'h1};
        vecs[4]  = '{4'h1, 4'h6, 4'h1, 4'h5, 4'h1, 64'h0,    64'h0,  N, N, N, 4'h5, 4'h5, 4'h5, 4'h1, 4'h1, N, 64'hDD, 64'h5, 64'h1, 64'h1};
        vecs[5]  = '{4'h1, 4'h6, 4'h1, 4'h5, 4'h1, 64'h0,    64'h0,  N, N, N, 4'h5, N, 4'h5, 4'h1, 4'h1, N,    64'hEE, 64'h5, 64'h1, 64'h1};
        vecs[6]  = '{4'h1, 4'hB, 4'h0, 4'h6, N,    64'h0,    64'h0,  N, N, N, N, N, 4'h4, 4'h4, 4'h4, 4'h6, 64'h4,  64'h4,  64'h4,  64'h4};
        vecs[7]  = '{4'h1, 4'h8, 4'h0, N,    N,    64'h0,    64'h40, 4'h4, N, N, N, N, N, 4'h4, 4'h4, N,      64'h40, 64'h40, 64'hAA, 64'h4};
        vecs[8]  = '{4'h1, 4'h7, 4'h0, N,    N,    64'h1234, 64'h80, N, N, N, N, N, N, N, N, N,                 64'h80, 64'h80, 64'h0,  64'h0};
        vecs[9]  = '{4'h1, 4'h3, 4'h0, N,    4'h7, 64'h99,   64'h0,  N, N, N, N, N, N, N, 4'h7, N,              64'h0,  64'h0,  64'h0,  64'h0};
        vecs[10] = '{4'h1, 4'h5, 4'h0, 4'h8, 4'h9, 64'h10,   64'h0,  N, N, N, 4'h9, N, N, 4'h9, N, 4'h8,        64'h0,  64'h0,  64'hEE, 64'h9};
        vecs[11] = '{4'h1, 4'h4, 4'h0, 4'hA, 4'hB, 64'h20,   64'h0,  N, N, 4'hB, N, 4'hB, 4'hA, 4'hB, N, N,     64'hA,  64'hA,  64'hCC, 64'hB};
        vecs[12] = '{4'h1, 4'h2, 4'h3, 4'hE, 4'h0, 64'h0,    64'h0,  N, N, N, N, N, 4'hE, N, 4'h0, N,           64'hE,  64'hE,  64'h0,  64'h0};
        vecs[13] = '{4'h3, 4'h9, 4'h0, N,    N,    64'h0,    64'h0,  N, N, N, N, N, 4'h4, 4'h4, 4'h4, N,        64'h4,  64'h4,  64'h4,  64'h4};
        vecs[14] = '{4'h1, 4'hA, 4'h0, 4'h3, N,    64'h0,    64'h0,  N, N, N, N, N, 4'h3, 4'h4, 4'h4, N,        64'h3,  64'h3,  64'h4,  64'h4};
        vecs[15] = '{4'h2, 4'h0, 4'h0, N,    N,    64'h0,    64'h0,  N, N, N, N, N, N, N, N, N,                 64'h0,  64'h0,  64'h0,  64'h0};

        for (int k = 0; k < 15; k++)
            reg_file_flat[k*64 +: 64] = 64'(k);
        e_valE = 64'hAA; M_valE = 64'hBB; m_valM = 64'hCC; W_valM = 64'hDD; W_valE = 64'hEE;
        E_stall = 1'b0; E_bubble = 1'b0;
        rst = 1'b1;
        drive_vec(vecs[0]);

        // Reset state, held through an edge and after release until the next edge.
        #1;
        check("rst icode", 64'(E_icode), 64'h1);
        check("rst stat",  64'(E_stat),  64'h1);
        check("rst dstE",  64'(E_dstE),  64'hF);
        check("rst valA",  E_valA,       64'h0);
        check("rst srcA",  64'(E_srcA),  64'hF);
        @(posedge clk); #1;
        check("rst edge icode", 64'(E_icode), 64'h1);
        rst = 1'b0;
        #2;
        check("post-rst hold icode", 64'(E_icode), 64'h1);
        @(posedge clk); #1;
        check("first load icode", 64'(E_icode), 64'h6);
        check("first load valA",  E_valA,       64'h2);

        // Vector table.
        for (int i = 0; i < 16; i++) begin
            drive_vec(vecs[i]);
            #2;
            check($sformatf("v%0d d_srcA", i), 64'(d_srcA), 64'(vecs[i].x_srca));
            check($sformatf("v%0d d_srcB", i), 64'(d_srcB), 64'(vecs[i].x_srcb));
            @(posedge clk); #1;
            check($sformatf("v%0d E_stat", i),  64'(E_stat),  64'(vecs[i].stat));
            check($sformatf("v%0d E_icode", i), 64'(E_icode), 64'(vecs[i].icode));
            check($sformatf("v%0d E_ifun", i),  64'(E_ifun),  64'(vecs[i].ifun));
            check($sformatf("v%0d E_valC", i),  E_valC,       vecs[i].valc);
            check($sformatf("v%0d E_valA", i),  E_valA,       FWD ? vecs[i].x_vala_f : vecs[i].x_vala_n);
            check($sformatf("v%0d E_valB", i),  E_valB,       FWD ? vecs[i].x_valb_f : vecs[i].x_valb_n);
            check($sformatf("v%0d E_dstE", i),  64'(E_dstE),  64'(vecs[i].x_dste));
            check($sformatf("v%0d E_dstM", i),  64'(E_dstM),  64'(vecs[i].x_dstm));
            check($sformatf("v%0d E_srcA", i),  64'(E_srcA),  64'(vecs[i].x_srca));
            check($sformatf("v%0d E_srcB", i),  64'(E_srcB),  64'(vecs[i].x_srcb));
        end

        // Stall: load irmovq, then hold it for two cycles while D changes.
        drive_vec(vecs[9]);
        @(posedge clk); #1;
        drive_vec(vecs[0]);
        E_stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d icode", c), 64'(E_icode), 64'h3);
            check($sformatf("stall%0d valC", c),  E_valC,       64'h99);
            check($sformatf("stall%0d dstE", c),  64'(E_dstE),  64'h7);
        end

        // Stall and bubble together: bubble wins.
        E_bubble = 1'b1;
        @(posedge clk); #1;
        check("bubble icode", 64'(E_icode), 64'h1);
        check("bubble stat",  64'(E_stat),  64'h1);
        check("bubble valC",  E_valC,       64'h0);
        check("bubble dstE",  64'(E_dstE),  64'hF);
        check("bubble valA",  E_valA,       64'h0);
        E_bubble = 1'b0;
        E_stall  = 1'b0;
        @(posedge clk); #1;
        check("resume icode", 64'(E_icode), 64'h6);
        check("resume valB",  E_valB,       64'h3);

        // Asynchronous reset mid-cycle.
        #2;
        rst = 1'b1;
        #1;
        check("async rst icode", 64'(E_icode), 64'h1);
        check("async rst valB",  E_valB,       64'h0);
        check("async rst dstE",  64'(E_dstE),  64'hF);
        @(posedge clk); #1;
        check("rst held icode", 64'(E_icode), 64'h1);
        rst = 1'b0;
        #1;
        check("rst released icode", 64'(E_icode), 64'h1);
        @(posedge clk); #1;
        check("reload icode", 64'(E_icode), 64'h6);
        check("reload dstE",  64'(E_dstE),  64'h3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
